// File: rtl/post_host_tx.sv
// Host-side initiator for the Acorn POST protocol: converts SYNC/OUTPUT/RAW
// commands into timed testreq pulse groups and samples the synchronised testack.
module post_host_tx #(
   parameter int PWID_CYC  = 1,
   parameter int PGAP_CYC  = 1,
   parameter int BREAK_CYC = 50
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd,
   input  logic [7:0] cmd_data,
   output logic       testreq,
   input  logic       testack,
   output logic       busy,
   output logic       done,
   output logic       rsp_ack,
   output logic       err
);

   typedef enum logic [2:0] {IDLE, HIGH, GAP, BRK, NEXT} state_t;
   typedef enum logic [1:0] {PH_SYNC, PH_OREQ, PH_BIT, PH_CHASE} phase_t;

   localparam logic [15:0] PWID_LD  = 16'(PWID_CYC - 1);
   localparam logic [15:0] PGAP_LD  = 16'(PGAP_CYC - 1);
   localparam logic [15:0] BREAK_LD = 16'(BREAK_CYC - 1);

   state_t      state_q, state_d;
   phase_t      phase_q, phase_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  data_q, data_d;
   logic [4:0]  n_q, n_d;
   logic [4:0]  pcnt_q, pcnt_d;
   logic [15:0] timer_q, timer_d;
   logic        smp_q, smp_d;
   logic        rsp_q, rsp_d;
   logic        err_q, err_d;
   logic        ack_meta_q, ack_s_q;

   phase_t      cmd_phase, cont_phase;
   logic [4:0]  cmd_n, cont_n;
   logic [2:0]  cont_idx;
   logic        cont;

   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         phase_q    <= PH_SYNC;
         idx_q      <= '0;
         data_q     <= '0;
         n_q        <= '0;
         pcnt_q     <= '0;
         timer_q    <= '0;
         smp_q      <= 1'b0;
         rsp_q      <= 1'b0;
         err_q      <= 1'b0;
         ack_meta_q <= 1'b0;
         ack_s_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         idx_q      <= idx_d;
         data_q     <= data_d;
         n_q        <= n_d;
         pcnt_q     <= pcnt_d;
         timer_q    <= timer_d;
         smp_q      <= smp_d;
         rsp_q      <= rsp_d;
         err_q      <= err_d;
         ack_meta_q <= testack;
         ack_s_q    <= ack_meta_q;
      end
   end

   // First group of a freshly accepted command, and the follow-on group of an OUTPUT
   always_comb begin
      cmd_phase = PH_SYNC;
      cmd_n     = 5'd4;
      if (cmd == 2'd1) begin
         cmd_phase = PH_OREQ;
         cmd_n     = 5'd3;
      end else if (cmd == 2'd2) begin
         cmd_n = (cmd_data[4:0] == 5'd0) ? 5'd1 : cmd_data[4:0];
      end

      cont       = 1'b0;
      cont_phase = phase_q;
      cont_idx   = idx_q;
      cont_n     = 5'd1;
      case (phase_q)
         PH_OREQ: begin
            if (smp_q) begin
               cont       = 1'b1;
               cont_phase = PH_BIT;
               cont_idx   = 3'd7;
               cont_n     = data_q[7] ? 5'd2 : 5'd1;
            end
         end
         PH_BIT: begin
            cont = 1'b1;
            if (idx_q == 3'd0) begin
               cont_phase = PH_CHASE;
               cont_n     = 5'd12;
            end else begin
               cont_idx = idx_q - 3'd1;
               cont_n   = data_q[idx_q - 3'd1] ? 5'd2 : 5'd1;
            end
         end
         default: cont = 1'b0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      idx_d     = idx_q;
      data_d    = data_q;
      n_d       = n_q;
      pcnt_d    = pcnt_q;
      timer_d   = timer_q;
      smp_d     = smp_q;
      rsp_d     = rsp_q;
      err_d     = err_q;
      done      = 1'b0;
      cmd_ready = 1'b0;

      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               state_d = HIGH;
               phase_d = cmd_phase;
               data_d  = cmd_data;
               n_d     = cmd_n;
               pcnt_d  = 5'd1;
               timer_d = PWID_LD;
            end
         end
         HIGH: begin
            if (timer_q == 16'd0) begin
               state_d = (pcnt_q == n_q) ? BRK : GAP;
               timer_d = (pcnt_q == n_q) ? BREAK_LD : PGAP_LD;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         GAP: begin
            if (timer_q == 16'd0) begin
               state_d = HIGH;
               pcnt_d  = pcnt_q + 5'd1;
               timer_d = PWID_LD;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         BRK: begin
            if (timer_q == 16'd0) begin
               state_d = NEXT;
               smp_d   = ack_s_q;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         NEXT: begin
            if (cont) begin
               state_d = HIGH;
               phase_d = cont_phase;
               idx_d   = cont_idx;
               n_d     = cont_n;
               pcnt_d  = 5'd1;
               timer_d = PWID_LD;
            end else begin
               // The completion cycle doubles as an accept slot for back-to-back commands
               done      = 1'b1;
               cmd_ready = 1'b1;
               rsp_d     = smp_q;
               err_d     = (phase_q == PH_OREQ);
               state_d   = IDLE;
               if (cmd_valid) begin
                  state_d = HIGH;
                  phase_d = cmd_phase;
                  data_d  = cmd_data;
                  n_d     = cmd_n;
                  pcnt_d  = 5'd1;
                  timer_d = PWID_LD;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign testreq = (state_q == HIGH);
   assign busy    = ~cmd_ready;
   assign rsp_ack = done ? smp_q : rsp_q;
   assign err     = done ? (phase_q == PH_OREQ) : err_q;

endmodule
